// File: rtl/pixel_frame_sequencer.sv
// Frame sequencer: pulls 8-bit pixels, pads the border with zeros and
// streams raster-ordered Q2.14 beats with row/col and frame markers.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start, busy, done  frame control (start pulse, busy level, done pulse)
//   s_valid, s_ready,
//   s_pixel            source pixel handshake, 8-bit unsigned pixel
//   m_valid, m_ready,
//   m_data             output beat handshake, Q2.14 data (0 on pad beats)
//   m_row, m_col       output position of the current beat
//   m_sof, m_eol,
//   m_eof              start of frame, end of line, end of frame
module pixel_frame_sequencer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PAD   = 1,
    parameter int CW    = $clog2(
        ((IMG_W + 2*PAD) > (IMG_H + 2*PAD)
            ? (IMG_W + 2*PAD) : (IMG_H + 2*PAD)) + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_pixel,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [15:0]   m_data,
    output logic [CW-1:0] m_row,
    output logic [CW-1:0] m_col,
    output logic          m_sof,
    output logic          m_eol,
    output logic          m_eof
);

    localparam int OUT_W = IMG_W + 2*PAD;
    localparam int OUT_H = IMG_H + 2*PAD;

    localparam logic [CW-1:0] LAST_C = CW'(OUT_W - 1);
    localparam logic [CW-1:0] LAST_R = CW'(OUT_H - 1);
    localparam logic [CW-1:0] LO     = CW'(PAD);
    localparam logic [CW-1:0] IW     = CW'(IMG_W);
    localparam logic [CW-1:0] IH     = CW'(IMG_H);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] r;
    logic [CW-1:0] c;
    logic          is_data;
    logic          can_load;
    logic          load;
    logic          last;

    // r-LO wraps to a value above IH/IW when r<LO, so one unsigned
    // compare per axis covers both the low and the high border.
    always_comb begin
        is_data  = ((r - LO) < IH) && ((c - LO) < IW);
        can_load = (state == S_RUN) && (!m_valid || m_ready);
        load     = can_load && (!is_data || s_valid);
        last     = (r == LAST_R) && (c == LAST_C);
    end

    assign s_ready = can_load && is_data;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            r     <= '0;
            c     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        r     <= '0;
                        c     <= '0;
                    end
                end
                S_RUN: begin
                    if (load) begin
                        if (last) begin
                            state <= S_DRAIN;
                            r     <= '0;
                            c     <= '0;
                        end else if (c == LAST_C) begin
                            c <= '0;
                            r <= r + CW'(1);
                        end else begin
                            c <= c + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (m_valid && m_ready) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register: loads a new beat in the same cycle the old one
    // retires, so a steady m_ready gives one beat per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_row   <= '0;
            m_col   <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= is_data ? {2'b00, s_pixel, 6'b0} : 16'h0000;
            m_row   <= r;
            m_col   <= c;
            m_sof   <= (r == '0) && (c == '0);
            m_eol   <= (c == LAST_C);
            m_eof   <= last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
